// File: rtl/alu_exec_pkg.sv
// alu_pkg: shared types and constants for the alu_exec execute stage.
//   alu_op_t    - 3-bit operation encoding presented on op
//   alu_state_t - execute-stage FSM state, also exported for observation
//   WIDTH       - datapath width (8 only)
//   HI_REG_DEFAULT - register that receives the multiply high byte
package alu_pkg;

  localparam int WIDTH = 8;
  localparam logic [3:0] HI_REG_DEFAULT = 4'hF;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_WB_LO   = 2'd2,
    ST_WB_HI   = 2'd3
  } alu_state_t;

endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: issue and write-back bundle between decode, alu_exec and the
// register file.
//   issue side : start, op, val1, val2, dst        (decode -> alu)
//   write-back : wb_en, wb_addr, wb_data           (alu -> register file)
//   status     : busy, zero, carry, state          (alu -> decode / observers)
//
// Handshake: start is an issue strobe that alu_exec samples on a rising edge
// only while busy is 0; one sampled start is one operation. While busy is 1
// the issuer must hold off, and any start it raises anyway is dropped, never
// queued. wb_en is a one-cycle write strobe with no back-pressure: the
// register file accepts every cycle wb_en is 1, and wb_addr/wb_data are
// meaningful only in those cycles.
interface alu_exec_if;
  import alu_pkg::*;

  logic       start;
  alu_op_t    op;
  logic [7:0] val1;
  logic [7:0] val2;
  logic [3:0] dst;

  logic       wb_en;
  logic [3:0] wb_addr;
  logic [7:0] wb_data;

  logic       busy;
  logic       zero;
  logic       carry;
  alu_state_t state;

  modport master (
    output start, op, val1, val2, dst,
    input  wb_en, wb_addr, wb_data, busy, zero, carry, state
  );

  modport slave (
    input  start, op, val1, val2, dst,
    output wb_en, wb_addr, wb_data, busy, zero, carry, state
  );

endinterface

// File: rtl/alu_exec_mul_seq.sv
// mul_seq: 8x8 unsigned shift-add multiplier, one partial product per step,
// multiplier LSB first.
//   clk, reset  - clock, synchronous active-low reset
//   load        - capture mcand_in/mplier_in, clear accumulator and step count
//   step        - perform one shift-add step
//   product     - accumulator including the partial product of the current
//                 step; once all steps are taken the multiplier is zero, so
//                 product then equals the final registered accumulator
//   done        - high during the eighth step (product is the full result)
module mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [7:0]  mcand_in,
  input  logic [7:0]  mplier_in,
  output logic [15:0] product,
  output logic        done
);

  logic [15:0] acc;
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [2:0]  count;

  // Exposing the post-step value lets the caller register the result on the
  // same edge that performs the last step, saving a cycle.
  assign product = acc + (mplier[0] ? mcand : 16'd0);
  assign done    = step && (count == 3'd7);

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {8'd0, mcand_in};
      mplier <= mplier_in;
      count  <= '0;
    end else if (step) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 3'd1;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute stage between register-file read and write-back.
//   clk   - system clock, rising edge
//   reset - synchronous, active-low
//   bus   - alu_exec_if.slave: issue inputs (start, op, val1, val2, dst),
//           write-back outputs (wb_en, wb_addr, wb_data), status outputs
//           (busy, zero, carry, state)
// Single-cycle ops write back in the cycle after issue. MUL runs 8 shift-add
// steps, then writes the low byte to dst and the high byte to HI_REG on two
// consecutive cycles. All outputs are registered.
module alu_exec
  import alu_pkg::*;
#(
  parameter int         WIDTH  = alu_pkg::WIDTH,
  parameter logic [3:0] HI_REG = HI_REG_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  alu_exec_if.slave  bus
);

  alu_state_t       state;
  logic             wb_en_q;
  logic [3:0]       wb_addr_q;
  logic [WIDTH-1:0] wb_data_q;
  logic             busy_q;
  logic             zero_q;
  logic             carry_q;
  logic [3:0]       mul_dst;

  logic [WIDTH-1:0] res;
  logic             res_c;
  logic [WIDTH:0]   sum9;
  logic [WIDTH:0]   diff9;
  logic [WIDTH:0]   shl9;
  logic [WIDTH:0]   shr9;
  logic [2:0]       sh;

  logic             mul_load;
  logic             mul_step;
  logic [15:0]      mul_product;
  logic             mul_done;

  // Single-cycle result. Shifts run in a 9-bit window so the last bit shifted
  // out lands in the spare bit (bit 8 for SHL, bit 0 for SHR); a shift of 0
  // leaves the spare bit clear, giving carry 0 without a special case.
  always_comb begin
    sh    = bus.val2[2:0];
    sum9  = {1'b0, bus.val1} + {1'b0, bus.val2};
    diff9 = {1'b0, bus.val1} - {1'b0, bus.val2};
    shl9  = {1'b0, bus.val1} << sh;
    shr9  = {bus.val1, 1'b0} >> sh;
    res   = '0;
    res_c = 1'b0;
    case (bus.op)
      OP_ADD: begin res = sum9[WIDTH-1:0];  res_c = sum9[WIDTH];  end
      OP_SUB: begin res = diff9[WIDTH-1:0]; res_c = diff9[WIDTH]; end
      OP_AND: res = bus.val1 & bus.val2;
      OP_OR:  res = bus.val1 | bus.val2;
      OP_XOR: res = bus.val1 ^ bus.val2;
      OP_SHL: begin res = shl9[WIDTH-1:0];  res_c = shl9[WIDTH];  end
      OP_SHR: begin res = shr9[WIDTH:1];    res_c = shr9[0];      end
      default: begin res = '0; res_c = 1'b0; end
    endcase
  end

  assign mul_load = (state == ST_IDLE) && bus.start && (bus.op == OP_MUL);
  assign mul_step = (state == ST_MUL_RUN);

  mul_seq u_mul (
    .clk       (clk),
    .reset     (reset),
    .load      (mul_load),
    .step      (mul_step),
    .mcand_in  (bus.val1),
    .mplier_in (bus.val2),
    .product   (mul_product),
    .done      (mul_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      busy_q    <= 1'b0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      mul_dst   <= '0;
    end else begin
      wb_en_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.op == OP_MUL) begin
              state   <= ST_MUL_RUN;
              busy_q  <= 1'b1;
              mul_dst <= bus.dst;
            end else begin
              wb_en_q   <= 1'b1;
              wb_addr_q <= bus.dst;
              wb_data_q <= res;
              zero_q    <= (res == '0);
              carry_q   <= res_c;
            end
          end
        end
        ST_MUL_RUN: begin
          // The eighth step and the low-byte write-back share one edge.
          if (mul_done) begin
            state     <= ST_WB_LO;
            wb_en_q   <= 1'b1;
            wb_addr_q <= mul_dst;
            wb_data_q <= mul_product[7:0];
            zero_q    <= (mul_product == 16'd0);
            carry_q   <= (mul_product[15:8] != 8'd0);
          end
        end
        ST_WB_LO: begin
          state     <= ST_WB_HI;
          wb_en_q   <= 1'b1;
          wb_addr_q <= HI_REG;
          wb_data_q <= mul_product[15:8];
        end
        ST_WB_HI: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wb_en   = wb_en_q;
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;
  assign bus.busy    = busy_q;
  assign bus.zero    = zero_q;
  assign bus.carry   = carry_q;
  assign bus.state   = state;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed table of single-cycle vectors plus hand-written
// multiply, drop-while-busy and reset-during-multiply sequences.
module tb_alu_exec;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_exec_if bus ();

  alu_exec dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    alu_op_t    op;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] d;
    logic [7:0] data;
    logic       z;
    logic       c;
  } vec_t;

  vec_t vecs[13];

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input alu_op_t op, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] d);
    bus.start = s;
    bus.op    = op;
    bus.val1  = a;
    bus.val2  = b;
    bus.dst   = d;
  endtask

  // Issue a MUL, optionally raise an ADD start mid-run, and check the full
  // 10-cycle busy window and both write-backs.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [3:0] d,
                         input logic [15:0] exp, input bit inject);
    logic exp_z;
    logic exp_c;
    exp_z = (exp == 16'd0);
    exp_c = (exp[15:8] != 8'd0);
    @(negedge clk);
    drive(1'b1, OP_MUL, a, b, d);
    @(posedge clk); #1;
    chk("mul k busy", 16'(bus.busy), 16'd1);
    chk("mul k wb_en", 16'(bus.wb_en), 16'd0);
    chk("mul k state", 16'(bus.state), 16'(ST_MUL_RUN));
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      if (inject && j == 3) drive(1'b1, OP_ADD, 8'h01, 8'h01, 4'd5);
      else drive(1'b0, OP_ADD, ~a, ~b, 4'd0);
      @(posedge clk); #1;
      chk($sformatf("mul k+%0d busy", j), 16'(bus.busy), 16'd1);
      chk($sformatf("mul k+%0d wb_en", j), 16'(bus.wb_en), 16'd0);
    end
    @(negedge clk);
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 4'd0);
    @(posedge clk); #1;
    chk("mul lo wb_en", 16'(bus.wb_en), 16'd1);
    chk("mul lo addr", 16'(bus.wb_addr), 16'(d));
    chk("mul lo data", 16'(bus.wb_data), 16'(exp[7:0]));
    chk("mul lo zero", 16'(bus.zero), 16'(exp_z));
    chk("mul lo carry", 16'(bus.carry), 16'(exp_c));
    chk("mul lo busy", 16'(bus.busy), 16'd1);
    @(posedge clk); #1;
    chk("mul hi wb_en", 16'(bus.wb_en), 16'd1);
    chk("mul hi addr", 16'(bus.wb_addr), 16'hF);
    chk("mul hi data", 16'(bus.wb_data), 16'(exp[15:8]));
    chk("mul hi busy", 16'(bus.busy), 16'd1);
    @(posedge clk); #1;
    chk("mul end busy", 16'(bus.busy), 16'd0);
    chk("mul end wb_en", 16'(bus.wb_en), 16'd0);
    chk("mul end state", 16'(bus.state), 16'(ST_IDLE));
    chk("mul end zero hold", 16'(bus.zero), 16'(exp_z));
    chk("mul end carry hold", 16'(bus.carry), 16'(exp_c));
  endtask

  // ---------------- test body ----------------
  initial begin
    vecs[0]  = '{OP_ADD, 8'hF0, 8'h20, 4'd3, 8'h10, 1'b0, 1'b1};
    vecs[1]  = '{OP_SUB, 8'h05, 8'h05, 4'd4, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{OP_SUB, 8'h03, 8'h04, 4'd5, 8'hFF, 1'b0, 1'b1};
    vecs[3]  = '{OP_SHL, 8'h81, 8'h01, 4'd6, 8'h02, 1'b0, 1'b1};
    vecs[4]  = '{OP_SHR, 8'h81, 8'h00, 4'd7, 8'h81, 1'b0, 1'b0};
    vecs[5]  = '{OP_AND, 8'hF0, 8'h0F, 4'd8, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{OP_OR,  8'hF0, 8'h0F, 4'd9, 8'hFF, 1'b0, 1'b0};
    vecs[7]  = '{OP_XOR, 8'hAA, 8'hFF, 4'd1, 8'h55, 1'b0, 1'b0};
    vecs[8]  = '{OP_SHR, 8'h81, 8'h01, 4'd2, 8'h40, 1'b0, 1'b1};
    vecs[9]  = '{OP_SHL, 8'h01, 8'h07, 4'd10, 8'h80, 1'b0, 1'b0};
    vecs[10] = '{OP_SHL, 8'h82, 8'h07, 4'd11, 8'h00, 1'b1, 1'b1};
    vecs[11] = '{OP_ADD, 8'h7F, 8'h01, 4'd12, 8'h80, 1'b0, 1'b0};
    vecs[12] = '{OP_SHR, 8'h07, 8'h0B, 4'd13, 8'h00, 1'b1, 1'b1};

    reset = 1'b0;
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst wb_en", 16'(bus.wb_en), 16'd0);
    chk("rst wb_addr", 16'(bus.wb_addr), 16'd0);
    chk("rst wb_data", 16'(bus.wb_data), 16'd0);
    chk("rst busy", 16'(bus.busy), 16'd0);
    chk("rst zero", 16'(bus.zero), 16'd0);
    chk("rst carry", 16'(bus.carry), 16'd0);
    chk("rst state", 16'(bus.state), 16'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;

    // Back-to-back single-cycle issue, one vector per edge.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d);
      @(posedge clk); #1;
      chk($sformatf("v%0d wb_en", i), 16'(bus.wb_en), 16'd1);
      chk($sformatf("v%0d addr", i), 16'(bus.wb_addr), 16'(vecs[i].d));
      chk($sformatf("v%0d data", i), 16'(bus.wb_data), 16'(vecs[i].data));
      chk($sformatf("v%0d zero", i), 16'(bus.zero), 16'(vecs[i].z));
      chk($sformatf("v%0d carry", i), 16'(bus.carry), 16'(vecs[i].c));
      chk($sformatf("v%0d busy", i), 16'(bus.busy), 16'd0);
    end
    @(negedge clk);
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 4'd0);
    @(posedge clk); #1;
    chk("idle wb_en", 16'(bus.wb_en), 16'd0);
    chk("idle zero hold", 16'(bus.zero), 16'd1);
    chk("idle carry hold", 16'(bus.carry), 16'd1);

    // Multiplies: drop-while-busy, dst==HI_REG overlap, zero product, small.
    run_mul(8'hFF, 8'hFF, 4'd2, 16'hFE01, 1'b1);
    run_mul(8'h10, 8'h10, 4'hF, 16'h0100, 1'b0);
    run_mul(8'h00, 8'h5A, 4'd9, 16'h0000, 1'b0);
    run_mul(8'h0D, 8'h0B, 4'd1, 16'h008F, 1'b0);
    run_mul(8'hFF, 8'hFF, 4'd3, 16'hFE01, 1'b0);

    // Reset during multiply step 4, with a start on the same edge.
    @(negedge clk);
    drive(1'b1, OP_MUL, 8'h0F, 8'h0F, 4'd6);
    @(posedge clk);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      drive(1'b0, OP_ADD, 8'h00, 8'h00, 4'd0);
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, OP_ADD, 8'h01, 8'h01, 4'd7);
    @(posedge clk); #1;
    chk("midrst busy", 16'(bus.busy), 16'd0);
    chk("midrst wb_en", 16'(bus.wb_en), 16'd0);
    chk("midrst zero", 16'(bus.zero), 16'd0);
    chk("midrst carry", 16'(bus.carry), 16'd0);
    chk("midrst state", 16'(bus.state), 16'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 4'd0);
    @(posedge clk); #1;
    chk("postrst wb_en", 16'(bus.wb_en), 16'd0);
    chk("postrst busy", 16'(bus.busy), 16'd0);
    @(negedge clk);
    drive(1'b1, OP_ADD, 8'h01, 8'h01, 4'd7);
    @(posedge clk); #1;
    chk("postrst add wb_en", 16'(bus.wb_en), 16'd1);
    chk("postrst add addr", 16'(bus.wb_addr), 16'd7);
    chk("postrst add data", 16'(bus.wb_data), 16'h02);
    chk("postrst add zero", 16'(bus.zero), 16'd0);
    chk("postrst add carry", 16'(bus.carry), 16'd0);
    @(negedge clk);
    drive(1'b0, OP_ADD, 8'h00, 8'h00, 4'd0);
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      chk($sformatf("quiet %0d wb_en", j), 16'(bus.wb_en), 16'd0);
    end

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute stage that sits directly downstream of the 16-entry, 8-bit register file: it consumes the two read-port values, performs the selected 8-bit operation, and drives the register file's write-back port (write enable, write address, write data). Single-cycle operations complete in one cycle. The 8×8 multiply is iterative and produces a 16-bit product written back over two cycles. A `busy` output stalls the upstream fetch/decode logic.

## Interface
Parameters:
- `WIDTH`, 8, datapath width; only 8 is supported.
- `HI_REG`, 4'hF, destination of the multiply high byte (rM).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `start`  in  1  issue strobe; sampled only when `busy`=0.
- `op`  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- `val1`  in  8  operand A (register file read port 1).
- `val2`  in  8  operand B (register file read port 2).
- `dst`  in  4  destination register address.
- `wb_en`  out  1  register-file write enable.
- `wb_addr`  out  4  register-file write address.
- `wb_data`  out  8  register-file write data.
- `busy`  out  1  multiply in progress; upstream must hold issue.
- `zero`  out  1  flag: last result was zero.
- `carry`  out  1  flag: carry/borrow/shift-out/overflow of the last result.

## Operation
- States: IDLE, MUL_RUN, WB_LO, WB_HI. `busy` = (state != IDLE).
- IDLE, `start`=1, op≠MUL: compute the result and register it.
  - Next cycle: `wb_en`=1, `wb_addr`=`dst`, `wb_data`=result.
  - State stays IDLE.
- IDLE, `start`=1, op=MUL: latch `val1`, `val2`, `dst`; clear the 16-bit accumulator and the 3-bit step count; go to MUL_RUN.
- MUL_RUN: one shift-add step per cycle, LSB of the multiplier first. After 8 steps, go to WB_LO.
- WB_LO: write the low byte to `dst`; go to WB_HI.
- WB_HI: write the high byte to `HI_REG`; go to IDLE.
- `start` while `busy`=1 is ignored. The operation is dropped, not queued.
- Arithmetic rules:
  - ADD: carry = bit 8 of the 9-bit sum.
  - SUB: A−B mod 256; carry = 1 when A<B (borrow).
  - SHL/SHR: logical shift by `val2[2:0]`; carry = last bit shifted out, 0 for a shift of 0.
  - AND/OR/XOR: carry = 0.
  - MUL: zero = (16-bit product == 0); carry = (high byte != 0).
- Flags update in the same cycle `wb_en` first asserts for that operation. For MUL this is WB_LO. Flags hold otherwise.
- `dst`=`HI_REG` on MUL: WB_LO writes the low byte, then WB_HI overwrites it with the high byte. This is the defined behaviour.
- `wb_en`=0 in every cycle not listed above. `wb_addr` and `wb_data` are don't-care while `wb_en`=0.

## Timing
- Reset values: state IDLE; `wb_en`=0, `wb_addr`=0, `wb_data`=0, `busy`=0, `zero`=0, `carry`=0; accumulator and step count cleared.
- Single-cycle op with `start` sampled at edge k: `wb_en` high for exactly the cycle after edge k.
  - A new `start` may be sampled at edge k+1, giving back-to-back issue.
- MUL with `start` sampled at edge k:
  - MUL_RUN from k+1 through k+8.
  - WB_LO write visible in the cycle after edge k+8; WB_HI write in the cycle after edge k+9.
  - IDLE after edge k+10.
  - `busy` high from after edge k until edge k+10; total 10 busy cycles.
- Reset asserted mid-multiply: IDLE at the next edge; any pending write-back is discarded and `wb_en`=0. Flags are cleared.
- Reset and `start` sampled at the same edge: reset wins and nothing is issued.
- Operands are sampled only at issue. Changes on `val1`/`val2` during MUL_RUN have no effect.

## Structure
- Package `alu_pkg`: op enum (`alu_op_t`), state enum (`alu_state_t`), `HI_REG` default, `WIDTH`.
- Sub-module `mul_seq`: 8-step shift-add multiplier with `load`, `step`, `product[15:0]`, `done`. `alu_exec` owns the FSM and the write-back mux.
- The write-back outputs connect directly to the register file's write port. `busy` gates the upstream issue logic.

## Test plan
- Reset, then ADD 0xF0+0x20 to dst 3 -> next cycle: `wb_en`=1, `wb_addr`=3, `wb_data`=0x10, carry=1, zero=0.
- SUB 0x05−0x05 to dst 4, then back-to-back SUB 0x03−0x04 -> first write: 0x00, zero=1, carry=0. Second write: 0xFF, carry=1.
- SHL 0x81 by 1, then SHR 0x81 by 0 -> first result 0x02, carry=1. Second result 0x81, carry=0.
- MUL 0xFF×0xFF to dst 2 -> 8 cycles of `busy` with `wb_en`=0; then 0x01 written to r2; then 0xFE written to r15; carry=1; `busy` falls after edge k+10.
- `start` ADD during a MUL -> ignored: no extra write, and the MUL results are unchanged.
- Reset asserted at MUL step 4 -> next cycle `busy`=0, `wb_en`=0, flags 0; a following ADD 1+1 writes 0x02 normally.
